// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register write-latency countdowns gating dual-issue source readiness
module issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int LAT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                iss0_valid,
  input  logic                iss0_rd_we,
  input  logic [3:0]          iss0_rd_addr,
  input  logic                iss0_rd2_we,
  input  logic [3:0]          iss0_rd2_addr,
  input  logic [LAT_W-1:0]    iss0_lat,
  input  logic                iss1_valid,
  input  logic                iss1_rd_we,
  input  logic [3:0]          iss1_rd_addr,
  input  logic                iss1_rd2_we,
  input  logic [3:0]          iss1_rd2_addr,
  input  logic [LAT_W-1:0]    iss1_lat,
  input  logic [3:0]          chk0_rs1_addr,
  input  logic [3:0]          chk0_rs2_addr,
  input  logic                chk0_rs1_used,
  input  logic                chk0_rs2_used,
  input  logic [3:0]          chk1_rs1_addr,
  input  logic [3:0]          chk1_rs2_addr,
  input  logic                chk1_rs1_used,
  input  logic                chk1_rs2_used,
  output logic                chk0_ready,
  output logic                chk1_ready,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                waw_same_cycle
);
  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
  logic [3:0] w_en;
  logic [3:0] w_a [4];
  logic [LAT_W-1:0] w_l [4];
  logic waw_nxt;
  // collect the four write ports; a flush discards every issue in its cycle
  always_comb begin
    w_en = {4{!flush}} & {iss1_valid & iss1_rd2_we, iss1_valid & iss1_rd_we,
                          iss0_valid & iss0_rd2_we, iss0_valid & iss0_rd_we};
    w_a[0] = iss0_rd_addr;
    w_a[1] = iss0_rd2_addr;
    w_a[2] = iss1_rd_addr;
    w_a[3] = iss1_rd2_addr;
    w_l[0] = iss0_lat;
    w_l[1] = iss0_lat;
    w_l[2] = iss1_lat;
    w_l[3] = iss1_lat;
  end
  // each counter decrements toward zero and is raised to the largest new latency aimed at it
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - ONE : '0;
      for (int i = 0; i < 4; i++)
        if (r != 0 && w_en[i] && w_a[i] == 4'(r) && w_l[i] > cnt_nxt[r]) cnt_nxt[r] = w_l[i];
      if (flush) cnt_nxt[r] = '0;
    end
  end
  // flag a slot0/slot1 collision on the same nonzero destination
  always_comb begin
    waw_nxt = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 2; j < 4; j++)
        if (w_en[i] && w_en[j] && w_a[i] == w_a[j] && w_a[i] != '0) waw_nxt = 1'b1;
  end
  // counter and collision-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      waw_same_cycle <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      waw_same_cycle <= waw_nxt;
    end
  end
  // readiness looks only at registered counters, never at this cycle's issues
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = r != 0 && cnt[r] != '0;
    chk0_ready = !(chk0_rs1_used && busy_mask[chk0_rs1_addr]) && !(chk0_rs2_used && busy_mask[chk0_rs2_addr]);
    chk1_ready = !(chk1_rs1_used && busy_mask[chk1_rs1_addr]) && !(chk1_rs2_used && busy_mask[chk1_rs2_addr]);
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: busy-until-cycle reference model with a queued scoreboard and decoupled monitor
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic rst, flush;
  logic iss0_valid, iss0_rd_we, iss0_rd2_we, iss1_valid, iss1_rd_we, iss1_rd2_we;
  logic [3:0] iss0_rd_addr, iss0_rd2_addr, iss1_rd_addr, iss1_rd2_addr;
  logic [2:0] iss0_lat, iss1_lat;
  logic [3:0] chk0_rs1_addr, chk0_rs2_addr, chk1_rs1_addr, chk1_rs2_addr;
  logic chk0_rs1_used, chk0_rs2_used, chk1_rs1_used, chk1_rs2_used;
  logic chk0_ready, chk1_ready, waw_same_cycle;
  logic [15:0] busy_mask;

  typedef struct packed {
    logic r0;
    logic r1;
    logic [15:0] bm;
    logic waw;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int bu[16];
  int mc = 0;
  bit m_waw = 0;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss0_valid(iss0_valid), .iss0_rd_we(iss0_rd_we), .iss0_rd_addr(iss0_rd_addr),
    .iss0_rd2_we(iss0_rd2_we), .iss0_rd2_addr(iss0_rd2_addr), .iss0_lat(iss0_lat),
    .iss1_valid(iss1_valid), .iss1_rd_we(iss1_rd_we), .iss1_rd_addr(iss1_rd_addr),
    .iss1_rd2_we(iss1_rd2_we), .iss1_rd2_addr(iss1_rd2_addr), .iss1_lat(iss1_lat),
    .chk0_rs1_addr(chk0_rs1_addr), .chk0_rs2_addr(chk0_rs2_addr),
    .chk0_rs1_used(chk0_rs1_used), .chk0_rs2_used(chk0_rs2_used),
    .chk1_rs1_addr(chk1_rs1_addr), .chk1_rs2_addr(chk1_rs2_addr),
    .chk1_rs1_used(chk1_rs1_used), .chk1_rs2_used(chk1_rs2_used),
    .chk0_ready(chk0_ready), .chk1_ready(chk1_ready),
    .busy_mask(busy_mask), .waw_same_cycle(waw_same_cycle)
  );

  always #5 clk = ~clk;

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, mc, act, exp);
    end
  endtask

  // monitor: samples just before the rising edge, pops the expectation for this cycle
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("chk0_ready", 16'(chk0_ready), 16'(e.r0));
      cmp("chk1_ready", 16'(chk1_ready), 16'(e.r1));
      cmp("busy_mask", busy_mask, e.bm);
      cmp("waw_same_cycle", 16'(waw_same_cycle), 16'(e.waw));
    end
  end

  // register r is busy in cycle c while c <= bu[r], the last cycle any in-flight write still covers
  task automatic tick(bit en);
    exp_t e;
    bit wv[4];
    logic [3:0] wa[4];
    int wl[4];
    for (int r = 0; r < 16; r++) e.bm[r] = (r != 0) && (bu[r] >= mc);
    e.r0 = !(chk0_rs1_used && e.bm[chk0_rs1_addr]) && !(chk0_rs2_used && e.bm[chk0_rs2_addr]);
    e.r1 = !(chk1_rs1_used && e.bm[chk1_rs1_addr]) && !(chk1_rs2_used && e.bm[chk1_rs2_addr]);
    e.waw = m_waw;
    if (en) q.push_back(e);
    if (rst || flush) begin
      for (int r = 0; r < 16; r++) bu[r] = -1;
      m_waw = 0;
    end else begin
      wv = '{iss0_valid && iss0_rd_we, iss0_valid && iss0_rd2_we, iss1_valid && iss1_rd_we, iss1_valid && iss1_rd2_we};
      wa = '{iss0_rd_addr, iss0_rd2_addr, iss1_rd_addr, iss1_rd2_addr};
      wl = '{int'(iss0_lat), int'(iss0_lat), int'(iss1_lat), int'(iss1_lat)};
      for (int i = 0; i < 4; i++)
        if (wv[i] && wa[i] != 0 && mc + wl[i] > bu[wa[i]]) bu[wa[i]] = mc + wl[i];
      m_waw = 0;
      for (int i = 0; i < 2; i++)
        for (int j = 2; j < 4; j++)
          if (wv[i] && wv[j] && wa[i] == wa[j] && wa[i] != 0) m_waw = 1;
    end
    mc++;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    iss0_valid = 0; iss0_rd_we = 0; iss0_rd_addr = 0; iss0_rd2_we = 0; iss0_rd2_addr = 0; iss0_lat = 0;
    iss1_valid = 0; iss1_rd_we = 0; iss1_rd_addr = 0; iss1_rd2_we = 0; iss1_rd2_addr = 0; iss1_lat = 0;
  endtask

  task automatic iss(int slot, logic [3:0] rd, logic [3:0] rd2, bit rd2_we, logic [2:0] lat);
    if (slot == 0) begin
      iss0_valid = 1; iss0_rd_we = 1; iss0_rd_addr = rd; iss0_rd2_we = rd2_we; iss0_rd2_addr = rd2; iss0_lat = lat;
    end else begin
      iss1_valid = 1; iss1_rd_we = 1; iss1_rd_addr = rd; iss1_rd2_we = rd2_we; iss1_rd2_addr = rd2; iss1_lat = lat;
    end
  endtask

  task automatic set_chk(logic [3:0] a0, logic [3:0] b0, bit u0, bit v0, logic [3:0] a1, logic [3:0] b1, bit u1, bit v1);
    chk0_rs1_addr = a0; chk0_rs2_addr = b0; chk0_rs1_used = u0; chk0_rs2_used = v0;
    chk1_rs1_addr = a1; chk1_rs2_addr = b1; chk1_rs1_used = u1; chk1_rs2_used = v1;
  endtask

  task automatic idle_n(int n);
    for (int k = 0; k < n; k++) begin idle(); tick(1); end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) bu[r] = -1;
    idle();
    set_chk(1, 2, 1, 1, 3, 4, 1, 1);
    @(negedge clk);
    rst = 1;
    tick(0);
    rst = 1;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      set_chk(4'($urandom), 4'($urandom), 1, 1, 4'($urandom), 4'($urandom), 1, 1);
      idle(); tick(1);
    end
    set_chk(5, 0, 1, 0, 5, 6, 1, 1);
    idle(); iss(0, 5, 0, 0, 3); tick(1);
    idle_n(5);
    set_chk(0, 0, 0, 0, 3, 7, 1, 1);
    idle(); iss(0, 2, 3, 1, 2); tick(1);
    idle_n(3);
    set_chk(0, 0, 0, 0, 3, 7, 0, 1);
    idle(); iss(0, 2, 3, 1, 2); tick(1);
    idle_n(3);
    set_chk(4, 1, 1, 0, 4, 4, 1, 1);
    idle(); iss(0, 4, 0, 0, 5); tick(1);
    idle(); iss(0, 4, 0, 0, 1); tick(1);
    idle_n(6);
    idle(); iss(0, 4, 0, 0, 2); iss(1, 4, 0, 0, 6); tick(1);
    idle_n(7);
    set_chk(0, 0, 1, 1, 0, 4, 1, 1);
    idle(); iss(0, 0, 0, 1, 7); tick(1);
    idle_n(2);
    set_chk(9, 10, 1, 1, 10, 9, 1, 1);
    idle(); iss(0, 9, 0, 0, 4); tick(1);
    idle(); flush = 1; iss(1, 10, 0, 0, 3); tick(1);
    idle_n(4);
    idle(); iss(0, 9, 0, 0, 4); tick(1);
    idle(); rst = 1; iss(1, 10, 0, 0, 3); tick(1);
    idle_n(4);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      iss0_valid = 1'($urandom); iss0_rd_we = 1'($urandom); iss0_rd2_we = ($urandom_range(0, 3) == 0);
      iss0_rd_addr = 4'($urandom); iss0_rd2_addr = 4'($urandom); iss0_lat = 3'($urandom);
      iss1_valid = 1'($urandom); iss1_rd_we = 1'($urandom); iss1_rd2_we = ($urandom_range(0, 3) == 0);
      iss1_rd_addr = 4'($urandom_range(0, 7)); iss1_rd2_addr = 4'($urandom); iss1_lat = 3'($urandom);
      set_chk(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      tick(1);
    end
    idle();
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register scoreboard feeding the dual-issue control path.
- Tracks in-flight writes to each architectural register with a per-register countdown. Reports whether the source operands of the next instruction pair are ready.
- The issue stage stalls a slot when its ready signal is low.
- Covers dependencies across cycles, such as multi-cycle MUL and loads. Same-cycle inst0->inst1 dependencies stay with the existing pairing logic.

Parameters:
- NUM_REGS, 16, architectural registers tracked (register 0 never tracked).
- LAT_W, 3, width of latency field and per-register counter (max latency 2^LAT_W-1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  clear all pending writes (branch redirect / pipeline flush)
- iss0_valid  input  1  slot 0 instruction issues this cycle
- iss0_rd_we  input  1  slot 0 writes rd
- iss0_rd_addr  input  4  slot 0 destination
- iss0_rd2_we  input  1  slot 0 writes second destination (UMULL/SMULL high half)
- iss0_rd2_addr  input  4  slot 0 second destination
- iss0_lat  input  LAT_W  cycles dependents must wait after issue; 0 = fully forwarded
- iss1_valid, iss1_rd_we, iss1_rd_addr, iss1_rd2_we, iss1_rd2_addr, iss1_lat  input  as slot 0  slot 1 issue
- chk0_rs1_addr, chk0_rs2_addr  input  4 each  slot 0 candidate sources
- chk0_rs1_used, chk0_rs2_used  input  1 each  source actually read
- chk1_rs1_addr, chk1_rs2_addr, chk1_rs1_used, chk1_rs2_used  input  as chk0  slot 1 candidate sources
- chk0_ready  output  1  all used slot 0 sources ready
- chk1_ready  output  1  all used slot 1 sources ready
- busy_mask  output  NUM_REGS  bit r = counter[r] != 0
- waw_same_cycle  output  1  registered pulse: both slots wrote the same nonzero register in one cycle

Behaviour:
- State is counter[1..NUM_REGS-1], LAT_W bits each. counter[0] is constant 0.
- Reset: all counters 0. busy_mask = 0, chk0_ready = chk1_ready = 1, waw_same_cycle = 0.
- Per cycle, per register r != 0:
  - base = counter[r] - 1 if nonzero, else 0.
  - Each issuing write (valid && we && addr == r && addr != 0) supplies its lat.
  - next counter[r] = max(base, all supplied lats).
  - Up to four writes per cycle: two slots, rd and rd2 each.
  - lat = 0 never raises a counter.
- Writes to register 0 are ignored. Sources addressing register 0 are always ready.
- Ready outputs are combinational from registered counters only. They are not affected by same-cycle issues.
  - Source s is ready iff !used || addr == 0 || counter[addr] == 0.
- Latency semantics: an instruction issued in cycle T with lat = L makes dependents not ready for cycles T+1 .. T+L, and ready at T+L+1.
- busy_mask is combinational from counters.
- waw_same_cycle is set for one cycle after any issue cycle in which a slot 0 write address equals a slot 1 write address (nonzero, both we, both valid). Counters still take the max.
- flush has priority over everything:
  - next counter = 0 for all registers, and issues in the same cycle are discarded.
  - waw_same_cycle next = 0.
- rst has priority over flush. Reset mid-countdown clears every counter in the next cycle.
- No wrap: counters only decrement to 0 and load values ≤ 2^LAT_W-1.

Test Plan:
- Reset then idle -> busy_mask = 0, chk0_ready = chk1_ready = 1 for any addresses.
- Issue slot0 rd = 5, lat = 3 at T; chk0_rs1 = 5 used -> chk0_ready = 0 at T+1..T+3, 1 at T+4; busy_mask[5] set T+1..T+3.
- Slot0 UMULL rd = 2, rd2 = 3, lat = 2; chk1 rs1 = 3, rs2 = 7 -> chk1_ready = 0 for 2 cycles. Same check with chk1_rs1_used = 0 -> ready = 1 throughout.
- WAW/max: rd = 4 lat 5 at T, then rd = 4 lat 1 at T+1 -> counter keeps 4 at T+2, ready at T+6. Same-cycle slot0/slot1 both rd = 4 (lat 2, 6) -> waw_same_cycle = 1 at T+1, counter = 6.
- Register 0: issue rd = 0 lat 7 -> busy_mask stays 0. chk rs1 = 0 used -> ready = 1.
- flush at T+1 with counters for r9 = 4 and a simultaneous slot1 issue rd = 10 lat 3 -> all counters 0 at T+2, r10 not busy. Repeat with rst instead of flush -> same result.
